uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer for the UART receive path, sitting directly downstream of the rx datapath/controller pair. Each completed frame's parallel byte, and optionally its framing-error status, is captured on a one-cycle write strobe. Bytes are presented to the host side through a show-ahead valid/ready interface. Overflow is reported with a sticky overrun flag; no received byte is silently reordered.

## Interface
- DATA_WIDTH, 8, bits per received character; must match the rx datapath.
- DEPTH, 16, number of entries; power of two, ≥ 2.
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  one-cycle strobe from rx controller: a frame finished (stop bit sampled).
- wr_data  input  DATA_WIDTH  received byte from the SIPO shift register; valid only with wr_valid.
- wr_frame_err  input  1  stop bit sampled low for this frame; valid only with wr_valid.
- rd_valid  output  1  head entry available (equals !empty).
- rd_ready  input  1  consumer accepts head entry this cycle.
- rd_data  output  DATA_WIDTH  head entry byte; 0 when empty.
- rd_frame_err  output  1  head entry framing-error tag; 0 when empty or when feature compiled out.
- count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overrun  output  1  sticky: a write was dropped because the FIFO was full.
- overrun_clr  input  1  clears overrun.

## Operation
- Storage: DEPTH-entry register array, read pointer and write pointer, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0; count is held as a separate register.
- Push: wr_valid && (!full || pop). Writes mem[wr_ptr], then wr_ptr+1.
- Pop: rd_valid && rd_ready. Advances rd_ptr; entry contents are not cleared.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with simultaneous pop and wr_valid: both succeed; count stays DEPTH; overrun is not set.
- Empty with wr_valid and rd_ready: push only (rd_valid is 0); count becomes 1.
- Drop: wr_valid && full && !pop. Byte is discarded, pointers and count are unchanged, overrun is set.
- overrun: set has priority over overrun_clr in the same cycle; otherwise overrun_clr clears it; otherwise it holds.
- rd_data and rd_frame_err are combinational from mem[rd_ptr], masked to 0 when empty.
- Reset: rd_ptr=0, wr_ptr=0, count=0, overrun=0. Outputs: empty=1, full=0, rd_valid=0, rd_data=0, rd_frame_err=0. Memory contents are not reset. Reset overrides any push or pop in the same cycle.
- No FSM; state is the pointers, count and overrun.

## Timing
- Write-to-read latency 1: wr_valid sampled at edge N means rd_valid=1 and the byte on rd_data after edge N.
- Pop at edge N: the next entry, or empty=1, is visible after edge N.
- full, empty, count and rd_valid are registered-state decodes with no combinational path from wr_valid. rd_ready feeds the push decision combinationally, for full-and-pop acceptance only.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- UART_RX_ERR_TAG_EN defined: each entry is DATA_WIDTH+1 bits wide and stores wr_frame_err; rd_frame_err reports the head tag.
- UART_RX_ERR_TAG_EN undefined: entries are DATA_WIDTH bits; wr_frame_err is ignored; rd_frame_err is tied to 0.

## Structure
- The shared UART package holds the DATA_WIDTH default and an rx_fifo_status_t struct (count, full, empty, overrun) used by the status register block.
- One sub-module: uart_rx_fifo_mem. It is the register array with one synchronous write port and one combinational read port, parameterised on width and depth.
- Pointer and count logic lives in the top module.

## Test plan
- Reset, then idle: empty=1, rd_valid=0, count=0, rd_data=0, overrun=0.
- Push 0x41, 0x42, 0x43 with rd_ready=0, then hold rd_ready=1 → rd_data reads 0x41, 0x42, 0x43 on consecutive cycles, then empty=1.
- Fill with 16 bytes 0x00..0x0F, then push 0xAA with rd_ready=0 → full=1, count=16, overrun=1. Drain yields 0x00..0x0F with no 0xAA.
- When full, push 0x55 in the same cycle as a pop → count stays 16, overrun=0, and 0x55 is read last after draining.
- Push 0x7E with wr_frame_err=1 → with UART_RX_ERR_TAG_EN, rd_frame_err=1 alongside 0x7E; without it, rd_frame_err=0.
- With overrun set, assert overrun_clr in the same cycle as another dropped write → overrun remains 1; overrun_clr alone the next cycle → overrun 0. Reset mid-drain → empty=1 the following cycle.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path definitions: default character width and the
// FIFO status bundle consumed by the status register block.
package uart_rx_fifo_pkg;

    localparam int RX_DATA_WIDTH = 8;
    localparam int RX_FIFO_DEPTH = 16;
    localparam int RX_FIFO_CNT_W = $clog2(RX_FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [RX_FIFO_CNT_W-1:0] count;
        logic                     full;
        logic                     empty;
        logic                     overrun;
    } rx_fifo_status_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port,
// one combinational read port. Contents are never reset.
module uart_rx_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART rx controller with a sticky overrun
// flag. Define UART_RX_ERR_TAG_EN to store the framing-error tag per entry.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH,
    parameter int DEPTH      = RX_FIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_frame_err,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_frame_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef UART_RX_ERR_TAG_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          ovr;
    logic          push;
    logic          pop;
    logic          drop;
    logic [MW-1:0] mem_wdata;
    logic [MW-1:0] mem_rdata;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign rd_valid = !empty;
    assign count    = cnt;
    assign overrun  = ovr;

    // A pop frees the slot a full-FIFO write lands in, so rd_ready gates acceptance.
    assign pop  = rd_valid && rd_ready;
    assign push = wr_valid && (!full || pop);
    assign drop = wr_valid && full && !pop;

`ifdef UART_RX_ERR_TAG_EN
    assign mem_wdata    = {wr_frame_err, wr_data};
    assign rd_frame_err = !empty && mem_rdata[DATA_WIDTH];
`else
    logic unused_frame_err;
    assign unused_frame_err = wr_frame_err;
    assign mem_wdata        = wr_data;
    assign rd_frame_err     = 1'b0;
`endif

    assign rd_data = empty ? '0 : mem_rdata[DATA_WIDTH-1:0];

    uart_rx_fifo_mem #(
        .WIDTH (MW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (push && !reset),
        .wr_addr (wr_ptr),
        .wr_data (mem_wdata),
        .rd_addr (rd_ptr),
        .rd_data (mem_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                ovr <= 1'b1;
            end else if (overrun_clr) begin
                ovr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based reference model decides
// acceptance; a negedge monitor checks every handshaked byte in order.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_frame_err = 1'b0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_frame_err;
    logic [4:0]    count;
    logic          full;
    logic          empty;
    logic          overrun;
    logic          overrun_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [DW:0] model_q[$];
    logic [DW:0] sb_q[$];
    logic        model_ovr = 1'b0;

    always #5 clock = ~clock;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_frame_err (wr_frame_err),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_frame_err (rd_frame_err),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head byte must match the oldest scoreboard entry.
    always @(negedge clock) begin
        if (!reset && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                chk("sb_head", int'({rd_frame_err, rd_data}), int'(sb_q.pop_front()));
            end
        end
    end

    task automatic check_status();
        int n;
        n = model_q.size();
        chk("count", int'(count), n);
        chk("full", int'(full), int'(n == DEPTH));
        chk("empty", int'(empty), int'(n == 0));
        chk("rd_valid", int'(rd_valid), int'(n != 0));
        chk("overrun", int'(overrun), int'(model_ovr));
        if (n == 0) begin
            chk("rd_data_empty", int'({rd_frame_err, rd_data}), 0);
        end else begin
            chk("rd_data_head", int'({rd_frame_err, rd_data}), int'(model_q[0]));
        end
    endtask

    // One clock of stimulus; the model is advanced using the specified rules.
    task automatic step(input logic rst, input logic wv, input logic [DW-1:0] wd,
                        input logic fe, input logic rr, input logic oc);
        logic fe_eff;
        logic pop;
        logic acc;
`ifdef UART_RX_ERR_TAG_EN
        fe_eff = fe;
`else
        fe_eff = 1'b0;
`endif
        reset = rst; wr_valid = wv; wr_data = wd; wr_frame_err = fe;
        rd_ready = rr; overrun_clr = oc;
        if (rst) begin
            model_q.delete();
            sb_q.delete();
            model_ovr = 1'b0;
        end else begin
            pop = (model_q.size() != 0) && rr;
            acc = wv && ((model_q.size() < DEPTH) || pop);
            if (pop) void'(model_q.pop_front());
            if (acc) begin
                model_q.push_back({fe_eff, wd});
                sb_q.push_back({fe_eff, wd});
            end
            if (wv && !acc) model_ovr = 1'b1;
            else if (oc) model_ovr = 1'b0;
        end
        @(posedge clock);
        #1;
        check_status();
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 1'b0, '0, 1'b0, rr, 1'b0);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic fe, input logic rr);
        step(1'b0, 1'b1, d, fe, rr, 1'b0);
    endtask

    initial begin
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);

        push(8'h41, 1'b0, 1'b0);
        push(8'h42, 1'b0, 1'b0);
        push(8'h43, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0, 1'b0);
        push(8'hAA, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i), 1'b0, 1'b0);
        push(8'h55, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        push(8'h7E, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        for (int i = 0; i < 6; i++) push(8'(8'hC0 + i), 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 99) < 60),
                 8'($urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 45 : 75)),
                 ($urandom_range(0, 19) == 0));
        end

        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
